// File: rtl/mmio_timer_console_if.sv
// mmio_timer_console_if: data-port bus and console TX stream between core side and the timer/console block
interface mmio_timer_console_if #(
  parameter int ADDR_WIDTH = 13
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            wr_mode;
  logic [31:0]           wdata;
  logic [31:0]           rdata;
  logic                  tx_valid;
  logic [7:0]            tx_data;
  logic                  tx_ready;
  modport master (
    output en, addr, wr_mode, wdata, tx_ready,
    input  rdata, tx_valid, tx_data
  );
  modport slave (
    input  en, addr, wr_mode, wdata, tx_ready,
    output rdata, tx_valid, tx_data
  );
endinterface

// File: rtl/mmio_timer_console.sv
// mmio_timer_console: memory-mapped 64-bit machine timer with compare irq and byte-wide console TX FIFO
module mmio_timer_console #(
  parameter int                    ADDR_WIDTH = 13,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h1FF0,
  parameter int                    PRESCALE   = 1,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                 sysclk,
  input  logic                 rst,
  mmio_timer_console_if.slave  bus,
  output logic                 irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [63:0]   mtime, mtimecmp, mtime_inc;
  logic [1:0]    ctrl;
  logic [15:0]   presc;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [4:0]    count;
  logic          overflow;
  logic          sel, rd, wr, tick, irq_pending, full, empty;
  logic          push_req, push, pop, drop, ovf_clr;
  logic [3:0]    off;
  logic [31:0]   status, rmux;
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction
  always_comb begin
    off         = bus.addr[3:0];
    sel         = bus.en && bus.addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    rd          = sel && bus.wr_mode == 4'd0;
    wr          = sel && bus.wr_mode != 4'd0;
    tick        = ctrl[0] && presc == 16'(PRESCALE - 1);
    mtime_inc   = mtime + 64'd1;
    irq_pending = mtime >= mtimecmp;
    irq         = irq_pending && ctrl[1];
    empty       = count == 5'd0;
    full        = count == 5'(FIFO_DEPTH);
    pop         = !empty && bus.tx_ready;
    push_req    = wr && off == 4'd6 && bus.wr_mode[0];
    // a full FIFO still accepts a push when the head leaves in the same cycle
    push        = push_req && (!full || pop);
    drop        = push_req && full && !pop;
    ovf_clr     = wr && off == 4'd5 && bus.wr_mode[0] && bus.wdata[3];
    status      = {23'd0, count, overflow, empty, full, irq_pending};
    rmux        = off == 4'd0 ? mtime[31:0] :
                  off == 4'd1 ? mtime[63:32] :
                  off == 4'd2 ? mtimecmp[31:0] :
                  off == 4'd3 ? mtimecmp[63:32] :
                  off == 4'd4 ? {30'd0, ctrl} :
                  off == 4'd5 ? status : 32'd0;
    bus.tx_valid = !empty;
    bus.tx_data  = mem[rd_ptr];
  end
  always_ff @(posedge sysclk) begin
    if (rst) begin
      bus.rdata <= 32'd0;
      mtime     <= 64'd0;
      mtimecmp  <= '1;
      ctrl      <= 2'd0;
      presc     <= 16'd0;
      overflow  <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= 5'd0;
    end else begin
      bus.rdata       <= rd ? rmux : 32'd0;
      presc           <= (tick || !ctrl[0]) ? 16'd0 : presc + 16'd1;
      // a write to one mtime word overrides that word's increment; the other word still counts
      mtime[31:0]     <= (wr && off == 4'd0) ? merge(mtime[31:0], bus.wdata, bus.wr_mode) :
                         tick ? mtime_inc[31:0] : mtime[31:0];
      mtime[63:32]    <= (wr && off == 4'd1) ? merge(mtime[63:32], bus.wdata, bus.wr_mode) :
                         tick ? mtime_inc[63:32] : mtime[63:32];
      mtimecmp[31:0]  <= (wr && off == 4'd2) ? merge(mtimecmp[31:0], bus.wdata, bus.wr_mode) : mtimecmp[31:0];
      mtimecmp[63:32] <= (wr && off == 4'd3) ? merge(mtimecmp[63:32], bus.wdata, bus.wr_mode) : mtimecmp[63:32];
      ctrl            <= (wr && off == 4'd4 && bus.wr_mode[0]) ? bus.wdata[1:0] : ctrl;
      overflow        <= drop || (overflow && !ovf_clr);
      rd_ptr          <= pop ? rd_ptr + PW'(1) : rd_ptr;
      wr_ptr          <= push ? wr_ptr + PW'(1) : wr_ptr;
      count           <= count + 5'(push) - 5'(pop);
    end
  end
  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= bus.wdata[7:0];
  end
endmodule

// File: tb/tb_mmio_timer_console.sv
// tb_mmio_timer_console: vector table plus rdata scoreboard and hand-written timer/FIFO sequences
module tb_mmio_timer_console;
  localparam logic [12:0] BASE = 13'h1FF0;
  localparam int NV = 21;
  logic sysclk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic vld_d = 1'b0;
  int errors = 0;
  int checks = 0;
  typedef struct { logic [31:0] exp; string nm; } sb_t;
  typedef struct { logic [12:0] a; logic [3:0] wm; logic [31:0] wd; logic [31:0] exp; string nm; } vec_t;
  sb_t  sb[$];
  sb_t  cur;
  vec_t vecs[NV];
  mmio_timer_console_if #(.ADDR_WIDTH(13)) bus();
  mmio_timer_console #(.ADDR_WIDTH(13), .BASE_ADDR(BASE), .PRESCALE(1), .FIFO_DEPTH(4)) dut (
    .sysclk(sysclk),
    .rst(rst),
    .bus(bus),
    .irq(irq)
  );
  always #5 sysclk = ~sysclk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // a read issued before an edge is compared on the following falling edge
  always @(posedge sysclk) vld_d <= !rst && bus.en && bus.wr_mode == 4'd0;
  always @(negedge sysclk) begin
    if (vld_d) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: rdata %h with no expected value", bus.rdata);
      end else begin
        cur = sb.pop_front();
        check(cur.nm, bus.rdata, cur.exp);
      end
    end
  end
  task automatic acc(input logic [12:0] a, input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] exp, input string nm);
    @(negedge sysclk);
    bus.en = 1'b1;
    bus.addr = a;
    bus.wr_mode = wm;
    bus.wdata = wd;
    if (wm == 4'd0) sb.push_back('{exp, nm});
  endtask
  task automatic wr(input logic [3:0] off, input logic [3:0] wm, input logic [31:0] wd);
    acc(BASE + 13'(off), wm, wd, 32'd0, "wr");
  endtask
  task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string nm);
    acc(BASE + 13'(off), 4'd0, 32'd0, exp, nm);
  endtask
  task automatic idle();
    @(negedge sysclk);
    bus.en = 1'b0;
    bus.wr_mode = 4'd0;
  endtask
  task automatic do_reset();
    @(negedge sysclk);
    rst = 1'b1;
    bus.en = 1'b0;
    bus.wr_mode = 4'd0;
    bus.tx_ready = 1'b0;
    @(negedge sysclk);
    rst = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] tail [3];
    bus.en = 1'b0;
    bus.addr = '0;
    bus.wr_mode = 4'd0;
    bus.wdata = 32'd0;
    bus.tx_ready = 1'b0;
    vecs[0]  = '{BASE + 13'd0, 4'h0, 32'h0, 32'h0000_0000, "rst_mtime_lo"};
    vecs[1]  = '{BASE + 13'd1, 4'h0, 32'h0, 32'h0000_0000, "rst_mtime_hi"};
    vecs[2]  = '{BASE + 13'd2, 4'h0, 32'h0, 32'hFFFF_FFFF, "rst_cmp_lo"};
    vecs[3]  = '{BASE + 13'd3, 4'h0, 32'h0, 32'hFFFF_FFFF, "rst_cmp_hi"};
    vecs[4]  = '{BASE + 13'd4, 4'h0, 32'h0, 32'h0000_0000, "rst_ctrl"};
    vecs[5]  = '{BASE + 13'd5, 4'h0, 32'h0, 32'h0000_0004, "rst_status"};
    vecs[6]  = '{BASE + 13'd6, 4'h0, 32'h0, 32'h0000_0000, "rst_txdata"};
    vecs[7]  = '{BASE + 13'd9, 4'h0, 32'h0, 32'h0000_0000, "unmapped_rd"};
    vecs[8]  = '{BASE + 13'd2, 4'h2, 32'hAABB_CCDD, 32'h0, "wr"};
    vecs[9]  = '{BASE + 13'd2, 4'h0, 32'h0, 32'hFFFF_CCFF, "byte_en_cmp_lo"};
    vecs[10] = '{BASE - 13'd16, 4'hF, 32'h1234_5678, 32'h0, "wr"};
    vecs[11] = '{BASE - 13'd1, 4'h0, 32'h0, 32'h0000_0000, "outside_rd"};
    vecs[12] = '{BASE + 13'd0, 4'h0, 32'h0, 32'h0000_0000, "outside_wr_no_effect"};
    vecs[13] = '{BASE + 13'd4, 4'hF, 32'hFFFF_FFFC, 32'h0, "wr"};
    vecs[14] = '{BASE + 13'd4, 4'h0, 32'h0, 32'h0000_0000, "ctrl_rsvd_bits"};
    vecs[15] = '{BASE + 13'd3, 4'h1, 32'h0, 32'h0, "wr"};
    vecs[16] = '{BASE + 13'd3, 4'h0, 32'h0, 32'hFFFF_FF00, "byte_en_cmp_hi"};
    vecs[17] = '{BASE + 13'd7, 4'hF, 32'h1, 32'h0, "wr"};
    vecs[18] = '{BASE + 13'd7, 4'h0, 32'h0, 32'h0000_0000, "unmapped_wr_rd"};
    vecs[19] = '{BASE + 13'd5, 4'h1, 32'hFFFF_FFFF, 32'h0, "wr"};
    vecs[20] = '{BASE + 13'd5, 4'h0, 32'h0, 32'h0000_0004, "status_ro"};
    do_reset();
    check("irq_rst", 32'(irq), 32'd0);
    check("tx_valid_rst", 32'(bus.tx_valid), 32'd0);
    for (int i = 0; i < NV; i++) acc(vecs[i].a, vecs[i].wm, vecs[i].wd, vecs[i].exp, vecs[i].nm);
    idle();
    idle();
    do_reset();
    wr(4'd0, 4'hF, 32'hFFFF_FFFE);
    wr(4'd4, 4'h1, 32'd1);
    repeat (3) idle();
    rd(4'd0, 32'd1, "carry_lo");
    rd(4'd1, 32'd1, "carry_hi");
    wr(4'd4, 4'h1, 32'd0);
    rd(4'd0, 32'd4, "freeze_a");
    rd(4'd0, 32'd4, "freeze_b");
    wr(4'd0, 4'hF, 32'd0);
    wr(4'd4, 4'h1, 32'd1);
    idle();
    idle();
    wr(4'd0, 4'h1, 32'hFFFF_FFAA);
    rd(4'd0, 32'h0000_00AA, "wr_during_inc_lo");
    rd(4'd1, 32'd1, "wr_during_inc_hi");
    idle();
    idle();
    do_reset();
    wr(4'd3, 4'hF, 32'd0);
    wr(4'd2, 4'hF, 32'd10);
    wr(4'd4, 4'h1, 32'd3);
    repeat (10) idle();
    check("irq_before_match", 32'(irq), 32'd0);
    idle();
    check("irq_at_match", 32'(irq), 32'd1);
    wr(4'd2, 4'hF, 32'd100);
    check("irq_during_cmp_wr", 32'(irq), 32'd1);
    idle();
    check("irq_after_cmp_wr", 32'(irq), 32'd0);
    wr(4'd2, 4'hF, 32'd0);
    wr(4'd4, 4'h1, 32'd1);
    rd(4'd5, 32'h5, "status_pending");
    check("irq_masked", 32'(irq), 32'd0);
    idle();
    idle();
    do_reset();
    check("fifo_empty_valid", 32'(bus.tx_valid), 32'd0);
    wr(4'd6, 4'h1, 32'h41);
    wr(4'd6, 4'h1, 32'h42);
    check("valid_after_push", 32'(bus.tx_valid), 32'd1);
    check("head_first", 32'(bus.tx_data), 32'h41);
    wr(4'd6, 4'h1, 32'h43);
    wr(4'd6, 4'h1, 32'h44);
    wr(4'd6, 4'h1, 32'h45);
    rd(4'd5, 32'h4A, "status_full_ovf");
    idle();
    check("head_hold", 32'(bus.tx_data), 32'h41);
    bus.tx_ready = 1'b1;
    check("drain_0", 32'(bus.tx_data), 32'h41);
    for (int k = 1; k < 4; k++) begin
      idle();
      check($sformatf("drain_%0d", k), 32'(bus.tx_data), 32'h41 + 32'(k));
    end
    idle();
    check("drained_valid", 32'(bus.tx_valid), 32'd0);
    bus.tx_ready = 1'b0;
    rd(4'd5, 32'h0C, "status_drained_ovf");
    wr(4'd5, 4'h1, 32'h8);
    rd(4'd5, 32'h04, "ovf_cleared");
    for (int k = 0; k < 4; k++) wr(4'd6, 4'h1, 32'h61 + 32'(k));
    rd(4'd5, 32'h42, "status_full");
    wr(4'd6, 4'h1, 32'h55);
    bus.tx_ready = 1'b1;
    rd(4'd5, 32'h42, "full_push_pop");
    bus.tx_ready = 1'b0;
    check("head_after_pp", 32'(bus.tx_data), 32'h62);
    idle();
    bus.tx_ready = 1'b1;
    check("pp_drain_0", 32'(bus.tx_data), 32'h62);
    tail[0] = 8'h63;
    tail[1] = 8'h64;
    tail[2] = 8'h55;
    for (int k = 0; k < 3; k++) begin
      idle();
      check($sformatf("pp_drain_%0d", k + 1), 32'(bus.tx_data), 32'(tail[k]));
    end
    idle();
    check("pp_drained_valid", 32'(bus.tx_valid), 32'd0);
    idle();
    idle();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: %0d reads never answered", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
